// File: rtl/dg_pkg.sv
// dg_pkg: shared types for the data-generator packet sequencer.
//  dg_desc_t      descriptor word layout {wait_cyc, len, prior, da} (27 bits)
//  dg_seq_state_e sequencer FSM states
package dg_pkg;

    localparam int DA_W   = 4;
    localparam int PRIO_W = 3;
    localparam int LEN_W  = 10;
    localparam int WAIT_W = 10;
    localparam int DESC_W = DA_W + PRIO_W + LEN_W + WAIT_W;

    typedef struct packed {
        logic [WAIT_W-1:0] wait_cyc;
        logic [LEN_W-1:0]  len;
        logic [PRIO_W-1:0] prior;
        logic [DA_W-1:0]   da;
    } dg_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RDW,
        ST_WAIT,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } dg_seq_state_e;

endpackage

// File: rtl/dg_pkt_seq.sv
// dg_pkt_seq: walks descriptors 0..NUM_DESC-1, idles each wait count, then streams its packet.
//  clk, rst_n              clock, asynchronous active-low reset
//  i_start                 run request, honoured only when idle
//  o_busy, o_done          run in progress, one-cycle completion pulse
//  o_ram_en/we/addr        descriptor RAM read port (we tied low)
//  i_ram_data              RAM read data, one cycle after o_ram_en
//  o_valid, i_ready        beat handshake
//  o_sop, o_eop, o_data    beat framing and payload {desc_idx[7:0], beat_idx[9:0]}
//  o_da, o_prior, o_len    header fields of the packet being sent
module dg_pkt_seq
    import dg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_DESC   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [3:0]            o_da,
    output logic [2:0]            o_prior,
    output logic [9:0]            o_len
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_DESC - 1);

    dg_seq_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    dg_desc_t              desc_q, desc_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [LEN_W-1:0]      beat_q, beat_d;
    dg_desc_t              ram_desc;
    logic [7:0]            desc_idx;
    logic                  last_beat;

    assign ram_desc  = dg_desc_t'(i_ram_data[DESC_W-1:0]);
    assign desc_idx  = 8'({8'd0, idx_q});
    assign last_beat = beat_q == desc_q.len - LEN_W'(1);

    if (DATA_WIDTH > DESC_W) begin : g_spare
        logic unused_ram_bits;
        assign unused_ram_bits = ^i_ram_data[DATA_WIDTH-1:DESC_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            desc_q  <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            desc_q  <= desc_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        desc_d  = desc_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RD;
                    idx_d   = '0;
                end
            end
            ST_RD: state_d = ST_RDW;
            ST_RDW: begin
                // Routing decided from the raw RAM word; the register is only loaded now.
                desc_d  = ram_desc;
                wait_d  = ram_desc.wait_cyc;
                beat_d  = '0;
                state_d = (ram_desc.len == '0) ? ST_NEXT :
                          (ram_desc.wait_cyc == '0) ? ST_SEND : ST_WAIT;
            end
            ST_WAIT: begin
                wait_d  = wait_q - WAIT_W'(1);
                state_d = (wait_q == WAIT_W'(1)) ? ST_SEND : ST_WAIT;
            end
            ST_SEND: begin
                if (i_ready) begin
                    beat_d  = last_beat ? '0 : beat_q + LEN_W'(1);
                    state_d = last_beat ? ST_NEXT : ST_SEND;
                end
            end
            ST_NEXT: begin
                state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_RD;
                idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + ADDR_WIDTH'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy     = state_q != ST_IDLE;
    assign o_done     = state_q == ST_DONE;
    assign o_ram_en   = state_q == ST_RD;
    assign o_ram_we   = 1'b0;
    assign o_ram_addr = idx_q;
    assign o_valid    = state_q == ST_SEND;
    assign o_sop      = o_valid && beat_q == '0;
    assign o_eop      = o_valid && last_beat;
    assign o_data     = DATA_WIDTH'({desc_idx, beat_q});
    assign o_da       = desc_q.da;
    assign o_prior    = desc_q.prior;
    assign o_len      = desc_q.len;

endmodule

// File: tb/tb_dg_pkt_seq.sv
// tb_dg_pkt_seq: directed self-checking bench for dg_pkt_seq with a descriptor RAM model.
module tb_dg_pkt_seq;
    import dg_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int ND = 10;
    localparam int BV = DW + 19;

    typedef logic [BV-1:0] bvec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_busy, o_done, o_ram_en, o_ram_we, o_valid, o_sop, o_eop;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] i_ram_data = '0;
    logic [DW-1:0] o_data;
    logic [3:0]    o_da;
    logic [2:0]    o_prior;
    logic [9:0]    o_len;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int compared = 0;
    int mismatched = 0;

    bvec_t beats[$];
    int    beat_cyc[$];
    int    en_addrs[$];
    int    first_en, first_val, done_cnt, done_cyc, stall_bad;

    dg_pkt_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_DESC(ND)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .i_ram_data(i_ram_data), .o_valid(o_valid), .i_ready(i_ready), .o_sop(o_sop),
        .o_eop(o_eop), .o_data(o_data), .o_da(o_da), .o_prior(o_prior), .o_len(o_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (o_ram_en) i_ram_data <= mem[o_ram_addr];

    // Upper five bits carry junk so the ignored field is exercised.
    function automatic logic [DW-1:0] mk(int w, int l, int p, int d);
        return {5'b10110, 10'(w), 10'(l), 3'(p), 4'(d)};
    endfunction

    function automatic bvec_t exp_beat(int d, int b, int len, int prior, int da);
        return {DW'((d % 256) * 1024 + b), b == 0, b == len - 1, 4'(da), 3'(prior), 10'(len)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = mk(3, 0, 0, 0);
    endtask

    task automatic run(input bit toggle, input int restart_at, input int stop_beats, input int budget);
        bit    stalled = 0;
        bit    seen_done = 0;
        int    tail = 0;
        bvec_t held = '0;
        bvec_t now;
        beats.delete();
        beat_cyc.delete();
        en_addrs.delete();
        first_en = -1;
        first_val = -1;
        done_cnt = 0;
        done_cyc = -1;
        stall_bad = 0;
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < budget && tail < 3; c++) begin
            @(negedge clk);
            now = {o_data, o_sop, o_eop, o_da, o_prior, o_len};
            if (stalled && (!o_valid || now !== held)) stall_bad++;
            stalled = o_valid && !i_ready;
            held = now;
            if (o_ram_en) begin
                en_addrs.push_back(int'(o_ram_addr));
                if (first_en < 0) first_en = c;
            end
            if (o_valid && first_val < 0) first_val = c;
            if (o_valid && i_ready) begin
                beats.push_back(now);
                beat_cyc.push_back(c);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = c;
                seen_done = 1;
            end
            if (seen_done) tail++;
            if (stop_beats > 0 && beats.size() == stop_beats) return;
            @(posedge clk);
            #1;
            i_start = (c + 1 == restart_at);
            if (toggle) i_ready = ~i_ready;
        end
        i_start = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({o_busy, o_done, o_ram_en, o_ram_we, o_valid, o_sop, o_eop} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 0000000", {o_busy, o_done, o_ram_en, o_ram_we, o_valid, o_sop, o_eop});
        end
        compared++;
        if ({o_ram_addr, o_data, o_da, o_prior, o_len} !== '0) begin
            mismatched++;
            $display("FAIL reset_data: addr %0d data %0h da %0d prior %0d len %0d want all 0", o_ram_addr, o_data, o_da, o_prior, o_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        clear_mem();
        mem[0] = mk(0, 1, 6, 1);
        run(0, 0, 0, 200);
        compared++;
        if (first_en !== 1) begin mismatched++; $display("FAIL single_en_lat: got %0d want 1", first_en); end
        compared++;
        if (first_val !== 3) begin mismatched++; $display("FAIL single_valid_lat: got %0d want 3", first_val); end
        compared++;
        if (beats.size() !== 1) begin mismatched++; $display("FAIL single_count: got %0d want 1", beats.size()); end
        else begin
            compared++;
            if (beats[0] !== exp_beat(0, 0, 1, 6, 1)) begin mismatched++; $display("FAIL single_beat: got %h want %h", beats[0], exp_beat(0, 0, 1, 6, 1)); end
        end
        compared++;
        if (done_cnt !== 1) begin mismatched++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
        compared++;
        if (done_cyc !== 32) begin mismatched++; $display("FAIL single_done_cyc: got %0d want 32", done_cyc); end
        compared++;
        if (en_addrs.size() !== ND) begin mismatched++; $display("FAIL single_reads: got %0d want %0d", en_addrs.size(), ND); end
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("FAIL single_idle: busy %b want 0", o_busy); end
    endtask

    task automatic test_wait();
        clear_mem();
        mem[0] = mk(5, 4, 2, 9);
        run(0, 0, 0, 200);
        compared++;
        if (first_val !== 8) begin mismatched++; $display("FAIL wait_valid_lat: got %0d want 8", first_val); end
        compared++;
        if (beats.size() !== 4) begin mismatched++; $display("FAIL wait_count: got %0d want 4", beats.size()); end
        for (int b = 0; b < 4 && b < beats.size(); b++) begin
            compared++;
            if (beats[b] !== exp_beat(0, b, 4, 2, 9) || beat_cyc[b] !== 8 + b) begin
                mismatched++;
                $display("FAIL wait_beat%0d: got %h at %0d want %h at %0d", b, beats[b], beat_cyc[b], exp_beat(0, b, 4, 2, 9), 8 + b);
            end
        end
        compared++;
        if (done_cnt !== 1) begin mismatched++; $display("FAIL wait_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        clear_mem();
        mem[0] = mk(0, 64, 3, 5);
        run(1, 0, 0, 500);
        compared++;
        if (beats.size() !== 64) begin mismatched++; $display("FAIL stall_count: got %0d want 64", beats.size()); end
        for (int b = 0; b < 64 && b < beats.size(); b++) begin
            compared++;
            if (beats[b] !== exp_beat(0, b, 64, 3, 5)) begin
                mismatched++;
                $display("FAIL stall_beat%0d: got %h want %h", b, beats[b], exp_beat(0, b, 64, 3, 5));
            end
        end
        compared++;
        if (stall_bad !== 0) begin mismatched++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
        compared++;
        if (done_cnt !== 1) begin mismatched++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_skip();
        bvec_t exp[$];
        clear_mem();
        mem[0] = mk(1, 2, 1, 3);
        mem[1] = mk(0, 0, 5, 5);
        mem[2] = mk(2, 3, 4, 7);
        for (int b = 0; b < 2; b++) exp.push_back(exp_beat(0, b, 2, 1, 3));
        for (int b = 0; b < 3; b++) exp.push_back(exp_beat(2, b, 3, 4, 7));
        run(0, 0, 0, 300);
        compared++;
        if (beats.size() !== exp.size()) begin mismatched++; $display("FAIL skip_count: got %0d want %0d", beats.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < beats.size(); i++) begin
            compared++;
            if (beats[i] !== exp[i]) begin mismatched++; $display("FAIL skip_beat%0d: got %h want %h", i, beats[i], exp[i]); end
        end
        compared++;
        if (done_cnt !== 1) begin mismatched++; $display("FAIL skip_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_full_table();
        bvec_t exp[$];
        int    bad_addr = 0;
        int    l;
        clear_mem();
        for (int i = 0; i < ND; i++) begin
            l = (i == 4) ? 1023 : i + 1;
            mem[i] = mk(i % 3, l, i % 8, i);
            for (int b = 0; b < l; b++) exp.push_back(exp_beat(i, b, l, i % 8, i));
        end
        run(0, 50, 0, 3000);
        compared++;
        if (beats.size() !== exp.size()) begin mismatched++; $display("FAIL full_count: got %0d want %0d", beats.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < beats.size(); i++) begin
            compared++;
            if (beats[i] !== exp[i]) begin mismatched++; $display("FAIL full_beat%0d: got %h want %h", i, beats[i], exp[i]); end
        end
        for (int i = 0; i < en_addrs.size(); i++) if (en_addrs[i] !== i) bad_addr++;
        compared++;
        if (en_addrs.size() !== ND || bad_addr !== 0) begin
            mismatched++;
            $display("FAIL full_addr_order: got %0d reads with %0d out of order want %0d in order", en_addrs.size(), bad_addr, ND);
        end
        compared++;
        if (done_cnt !== 1) begin mismatched++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("FAIL full_restart_ignored: busy %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        for (int i = 0; i < 3; i++) mem[i] = mk(0, 1, i, i);
        mem[3] = mk(0, 1023, 7, 15);
        run(0, 0, 104, 3000);
        compared++;
        if (beats.size() !== 104 || o_data !== DW'(3 * 1024 + 100)) begin
            mismatched++;
            $display("FAIL mid_reach: got %0d beats data %h want 104 beats data %h", beats.size(), o_data, DW'(3 * 1024 + 100));
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({o_busy, o_done, o_ram_en, o_valid, o_sop, o_eop} !== 6'b0 ||
            {o_ram_addr, o_data, o_da, o_prior, o_len} !== '0) begin
            mismatched++;
            $display("FAIL mid_async_reset: busy %b valid %b addr %0d data %h da %0d len %0d want all 0",
                     o_busy, o_valid, o_ram_addr, o_data, o_da, o_len);
        end
        #3;
        rst_n = 1'b1;
        mem[3] = mk(0, 2, 7, 15);
        run(0, 0, 0, 300);
        compared++;
        if (en_addrs.size() < 1 || en_addrs[0] !== 0) begin
            mismatched++;
            $display("FAIL mid_replay_addr: got %0d reads first %0d want first 0", en_addrs.size(), en_addrs.size() > 0 ? en_addrs[0] : -1);
        end
        compared++;
        if (beats.size() !== 5) begin mismatched++; $display("FAIL mid_replay_count: got %0d want 5", beats.size()); end
        else begin
            compared++;
            if (beats[0] !== exp_beat(0, 0, 1, 0, 0) || beats[4] !== exp_beat(3, 1, 2, 7, 15)) begin
                mismatched++;
                $display("FAIL mid_replay_beats: got %h/%h want %h/%h", beats[0], beats[4], exp_beat(0, 0, 1, 0, 0), exp_beat(3, 1, 2, 7, 15));
            end
        end
        compared++;
        if (done_cnt !== 1) begin mismatched++; $display("FAIL mid_done_cnt: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wait();
        test_stall();
        test_skip();
        test_full_table();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
